// File: rtl/bus_responder.sv
// rtl/bus_responder.sv - CPU external-bus target: HRAM, IF/IE, boot latch, external port forwarding
// Decodes CPU cycles, commits writes on strobe rise and returns read data one clock after rd rises.
module bus_responder #(
  parameter bit HRAM_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a,
  input  logic        rd,
  input  logic        wr,
  input  logic [7:0]  dout,
  output logic [7:0]  din,
  input  logic [4:0]  irq_req,
  output logic        irq_pending,
  output logic [15:0] ext_a,
  output logic        ext_rd,
  output logic        ext_wr,
  output logic [7:0]  ext_dout,
  input  logic [7:0]  ext_din,
  output logic        boot_en
);

  typedef enum logic [2:0] {
    R_EXT  = 3'd0,
    R_IF   = 3'd1,
    R_BOOT = 3'd2,
    R_HRAM = 3'd3,
    R_IE   = 3'd4
  } region_e;

  region_e region;
  region_e rsel_q, rsel_d;

  logic       rd_q, rd_d, wr_q, wr_d;
  logic       rd_arm_q, rd_arm_d, wr_arm_q, wr_arm_d;
  logic [4:0] if_q, if_d, ie_q, ie_d;
  logic       boot_en_q, boot_en_d;
  logic       irq_pending_q, irq_pending_d;
  logic [7:0] reg_q, reg_d;
  logic [7:0] hram_q;
  logic       rd_start, wr_start;
  logic [6:0] hram_idx;

  always_comb begin
    region = R_EXT;
    if (a == 16'hFF0F)       region = R_IF;
    else if (a == 16'hFF50)  region = R_BOOT;
    else if (a == 16'hFFFF)  region = R_IE;
    else if (a[15:7] == 9'h1FF) region = R_HRAM;
  end

  assign hram_idx = a[6:0];

  // A strobe held high across reset release must go low once before it can count as an edge.
  assign rd_start = rd & ~rd_q & rd_arm_q;
  assign wr_start = wr & ~wr_q & wr_arm_q;

  always_comb begin
    rd_d     = rd;
    wr_d     = wr;
    rd_arm_d = rd_arm_q | ~rd;
    wr_arm_d = wr_arm_q | ~wr;

    if_d = if_q;
    if (wr_start && region == R_IF) if_d = dout[4:0];
    if_d = if_d | irq_req;

    ie_d = ie_q;
    if (wr_start && region == R_IE) ie_d = dout[4:0];

    boot_en_d = boot_en_q;
    if (wr_start && region == R_BOOT && dout != 8'h00) boot_en_d = 1'b0;

    irq_pending_d = |(if_d & ie_d);

    rsel_d = rsel_q;
    reg_d  = reg_q;
    if (rd_start) begin
      rsel_d = region;
      case (region)
        R_IF:    reg_d = {3'b111, if_q};
        R_IE:    reg_d = {3'b111, ie_q};
        default: reg_d = 8'hFF;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q          <= 1'b0;
      wr_q          <= 1'b0;
      rd_arm_q      <= 1'b0;
      wr_arm_q      <= 1'b0;
      if_q          <= 5'd0;
      ie_q          <= 5'd0;
      boot_en_q     <= 1'b1;
      irq_pending_q <= 1'b0;
      rsel_q        <= R_BOOT;
      reg_q         <= 8'hFF;
    end else begin
      rd_q          <= rd_d;
      wr_q          <= wr_d;
      rd_arm_q      <= rd_arm_d;
      wr_arm_q      <= wr_arm_d;
      if_q          <= if_d;
      ie_q          <= ie_d;
      boot_en_q     <= boot_en_d;
      irq_pending_q <= irq_pending_d;
      rsel_q        <= rsel_d;
      reg_q         <= reg_d;
    end
  end

  logic [7:0] hram_mem [0:126];

  generate
    if (HRAM_INIT) begin : g_hram_clr
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < 127; i++) hram_mem[i] <= 8'h00;
          hram_q <= 8'h00;
        end else begin
          if (wr_start && region == R_HRAM) hram_mem[hram_idx] <= dout;
          if (rd_start && region == R_HRAM) hram_q <= hram_mem[hram_idx];
        end
      end
    end else begin : g_hram_raw
      always_ff @(posedge clk) begin
        if (wr_start && region == R_HRAM) hram_mem[hram_idx] <= dout;
        if (rd_start && region == R_HRAM) hram_q <= hram_mem[hram_idx];
      end
    end
  endgenerate

  always_comb begin
    case (rsel_q)
      R_HRAM:  din = hram_q;
      R_EXT:   din = ext_din;
      default: din = reg_q;
    endcase
  end

  assign ext_a       = a;
  assign ext_dout    = dout;
  assign ext_rd      = rd & (region == R_EXT) & ~rst;
  assign ext_wr      = wr_start & (region == R_EXT) & ~rst;
  assign boot_en     = boot_en_q;
  assign irq_pending = irq_pending_q;

endmodule

// File: tb/tb_bus_responder.sv
// tb/tb_bus_responder.sv - directed self-checking bench for bus_responder
module tb_bus_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a;
  logic        rd, wr;
  logic [7:0]  dout, din, ext_dout, ext_din;
  logic [4:0]  irq_req;
  logic        irq_pending, ext_rd, ext_wr, boot_en;
  logic [15:0] ext_a;

  int checks = 0;
  int errors = 0;
  logic       mon_en = 1'b0;
  logic       ext_seen = 1'b0;
  logic [7:0] rv;

  bus_responder #(.HRAM_INIT(1'b1)) dut (
    .clk(clk), .rst(rst), .a(a), .rd(rd), .wr(wr), .dout(dout), .din(din),
    .irq_req(irq_req), .irq_pending(irq_pending), .ext_a(ext_a), .ext_rd(ext_rd),
    .ext_wr(ext_wr), .ext_dout(ext_dout), .ext_din(ext_din), .boot_en(boot_en)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mon_en && (ext_rd || ext_wr)) ext_seen <= 1'b1;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [15:0] addr, input logic [7:0] d);
    @(negedge clk); a = addr; dout = d; wr = 1'b1;
    @(posedge clk);
    @(negedge clk); wr = 1'b0;
    @(posedge clk);
  endtask

  task automatic bus_read(input logic [15:0] addr, output logic [7:0] d);
    @(negedge clk); a = addr; rd = 1'b1;
    @(posedge clk);
    @(negedge clk); d = din;
    @(posedge clk);
    @(negedge clk); rd = 1'b0;
    @(posedge clk);
  endtask

  initial begin
    rst = 1'b1; a = 16'h0000; rd = 1'b0; wr = 1'b0; dout = 8'h00;
    irq_req = 5'd0; ext_din = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    chk("reset_din", {8'h0, din}, 16'h00FF);
    chk("reset_boot_en", {15'h0, boot_en}, 16'h1);
    chk("reset_irq_pending", {15'h0, irq_pending}, 16'h0);
    chk("reset_ext_strobes", {14'h0, ext_rd, ext_wr}, 16'h0);
    bus_read(16'hFF50, rv);
    chk("read_boot", {8'h0, rv}, 16'h00FF);

    mon_en = 1'b1;
    bus_write(16'hFF80, 8'h5A);
    bus_write(16'hFFFE, 8'hA5);
    bus_read(16'hFF80, rv);
    chk("hram_ff80", {8'h0, rv}, 16'h005A);
    bus_read(16'hFFFE, rv);
    chk("hram_fffe", {8'h0, rv}, 16'h00A5);
    @(negedge clk);
    mon_en = 1'b0;
    chk("hram_no_ext_strobe", {15'h0, ext_seen}, 16'h0);

    bus_write(16'hFFFF, 8'h1F);
    bus_read(16'hFFFF, rv);
    chk("ie_read", {8'h0, rv}, 16'h00FF);
    bus_read(16'hFFFE, rv);
    chk("hram_fffe_after_ie", {8'h0, rv}, 16'h00A5);
    @(negedge clk); irq_req = 5'b00100;
    @(posedge clk);
    @(negedge clk); irq_req = 5'd0;
    chk("irq_pending_set", {15'h0, irq_pending}, 16'h1);
    bus_read(16'hFF0F, rv);
    chk("if_read_e4", {8'h0, rv}, 16'h00E4);
    bus_write(16'hFF0F, 8'h00);
    @(negedge clk);
    chk("irq_pending_clr", {15'h0, irq_pending}, 16'h0);

    @(negedge clk); irq_req = 5'b10010;
    @(negedge clk); irq_req = 5'd0;
    @(negedge clk); a = 16'hFF0F; dout = 8'h00; wr = 1'b1; irq_req = 5'b00001;
    @(posedge clk);
    @(negedge clk); wr = 1'b0; irq_req = 5'd0;
    chk("irq_pending_bit0", {15'h0, irq_pending}, 16'h1);
    bus_read(16'hFF0F, rv);
    chk("if_write_vs_set", {8'h0, rv}, 16'h00E1);

    @(negedge clk); a = 16'hFF0F; rd = 1'b1; irq_req = 5'b00010;
    @(posedge clk);
    @(negedge clk); irq_req = 5'd0;
    chk("if_read_pre_set", {8'h0, din}, 16'h00E1);
    @(negedge clk); rd = 1'b0;
    bus_read(16'hFF0F, rv);
    chk("if_read_post_set", {8'h0, rv}, 16'h00E3);

    @(negedge clk); a = 16'hC000; rd = 1'b1; ext_din = 8'h3C;
    #1;
    chk("ext_rd_e0", {15'h0, ext_rd}, 16'h1);
    chk("ext_a", ext_a, 16'hC000);
    @(posedge clk);
    @(negedge clk);
    chk("ext_rd_e1", {15'h0, ext_rd}, 16'h1);
    chk("ext_din_to_din", {8'h0, din}, 16'h003C);
    @(negedge clk); rd = 1'b0;
    #1;
    chk("ext_rd_drop", {15'h0, ext_rd}, 16'h0);

    @(negedge clk); a = 16'h8000; dout = 8'h77; wr = 1'b1;
    #1;
    chk("ext_wr_pulse", {15'h0, ext_wr}, 16'h1);
    chk("ext_dout", {8'h0, ext_dout}, 16'h0077);
    @(negedge clk);
    chk("ext_wr_single", {15'h0, ext_wr}, 16'h0);
    wr = 1'b0;

    bus_write(16'hFF50, 8'h01);
    @(negedge clk);
    chk("boot_disable", {15'h0, boot_en}, 16'h0);
    bus_write(16'hFF50, 8'h00);
    @(negedge clk);
    chk("boot_sticky", {15'h0, boot_en}, 16'h0);

    @(negedge clk); a = 16'h8000; dout = 8'h55; wr = 1'b1;
    #1;
    chk("ext_wr_pre_rst", {15'h0, ext_wr}, 16'h1);
    #1; rst = 1'b1;
    #1;
    chk("ext_wr_in_rst", {15'h0, ext_wr}, 16'h0);
    @(negedge clk); rst = 1'b0; a = 16'hFF80; dout = 8'h33;
    @(posedge clk);
    @(negedge clk);
    chk("boot_after_rst", {15'h0, boot_en}, 16'h1);
    a = 16'h8000;
    #1;
    chk("ext_wr_held_strobe", {15'h0, ext_wr}, 16'h0);
    @(negedge clk); wr = 1'b0;
    bus_read(16'hFF80, rv);
    chk("no_commit_after_rst", {8'h0, rv}, 16'h0000);
    bus_read(16'hFFFF, rv);
    chk("ie_after_rst", {8'h0, rv}, 16'h00E0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_responder.md
# bus_responder

Target side of the CPU's external memory bus. Decodes each CPU bus cycle from `a`/`rd`/`wr`/`dout` and returns read data on `din` in time for the CPU's sampling edge. It owns the on-chip resources: 127-byte HRAM, the IF and IE interrupt registers, and the boot-ROM disable latch. Every other address is forwarded to an external port serving cartridge, VRAM, WRAM and I/O. It sits between `cpu` and the rest of the SoC.

## Interface
- `HRAM_INIT`, default 0: if 1, HRAM clears to 0 on reset (bench use); otherwise HRAM contents are undefined after reset.
- `clk` in 1: system clock, same as the CPU.
- `rst` in 1: reset, asynchronous, active-high.
- `a` in 16: CPU address.
- `rd` in 1: CPU read strobe.
- `wr` in 1: CPU write strobe.
- `dout` in 8: CPU write data.
- `din` out 8: read data to the CPU.
- `irq_req` in 5: interrupt set pulses (bit 0 VBlank … bit 4 Joypad).
- `irq_pending` out 1: `|(IF & IE)`, registered.
- `ext_a` out 16: external address, equal to `a`.
- `ext_rd` out 1: external read strobe.
- `ext_wr` out 1: external write strobe.
- `ext_dout` out 8: external write data, equal to `dout`.
- `ext_din` in 8: external read data.
- `boot_en` out 1: 1 while the boot ROM overlays 0x0000–0x00FF.

## Operation
- Address decode:
  - 0xFF0F: IF.
  - 0xFF50: BOOT.
  - 0xFF80–0xFFFE: HRAM, index `a - 0xFF80`.
  - 0xFFFF: IE.
  - All other addresses: EXT.
- Read start is detected as `rd & !rd_q`, with `rd_q` a registered copy of `rd`. At that edge:
  - latch region select `rsel`;
  - HRAM performs its synchronous read;
  - the IF/IE/BOOT value is captured into `reg_q`.
- `din` is a combinational mux on `rsel`:
  - HRAM → `hram_q`;
  - EXT → `ext_din`;
  - IF → `{3'b111, IF}`;
  - IE → `{3'b111, IE}`;
  - BOOT → 0xFF.
- `din` holds its value until the next read start.
- `ext_rd = rd & (region==EXT) & !rst`. External devices are synchronous-read and register data on the same edge as the read start.
- Write commit occurs on `wr & !wr_q`: exactly one commit per `wr` pulse, written to the decoded target.
- `ext_wr = wr & (region==EXT) & !wr_q & !rst`: a one-cycle pulse.
- IF, per bit, on each clock:
  - `irq_req` set has priority;
  - otherwise a CPU write loads the bit;
  - otherwise the bit holds.
- IE: 5-bit register. Writes store `dout[4:0]`; `dout[7:5]` is ignored.
- BOOT: a write with `dout != 0` clears `boot_en`. The latch is sticky until reset.
  - `boot_en` is forwarded to EXT logic; it does not change decode here.
- `irq_pending` is registered from next-state IF and IE. It is valid the cycle after any change.

## Timing
- CPU T-cycle: E0 drives `a`/`rd`; E1 is idle; E2 samples `din` and raises `wr`; E3 drops `wr`.
- Read:
  - the responder sees `rd=1` at E1 and registers the data there;
  - `din` is valid from E1 to E2;
  - latency from the read strobe rising is one clock.
- Write: `wr` is seen at E3, and the commit happens at E3. Read-after-write on the next M-cycle returns the new value.
- Reset values:
  - `din` = 0xFF (`rsel` = BOOT);
  - IF = 0, IE = 0, `boot_en` = 1, `irq_pending` = 0;
  - `rd_q` = 0, `wr_q` = 0;
  - `ext_rd` = 0, `ext_wr` = 0.
- Reset asserted mid-cycle: the strobes drop immediately and no write commits. After release, a strobe that is already high does not count as an edge until it has been low for one clock.
- Simultaneous events:
  - CPU write to IF in the same clock as `irq_req` for bit n: bit n = 1, other bits take `dout`.
  - CPU reads IF while `irq_req` is set: returns the pre-set value.
- HRAM index wraps nowhere. 0xFFFF never aliases HRAM.

## Test plan
- Reset, then read 0xFF50 → `din` = 0xFF, `boot_en` = 1, `irq_pending` = 0.
- Write 0x5A to 0xFF80 and 0xA5 to 0xFFFE, then read both → 0x5A and 0xA5, valid at E2. `ext_rd` and `ext_wr` never assert.
- Write 0x1F to 0xFFFF, pulse `irq_req` = 5'b00100 → IF reads 0xE4, and `irq_pending` = 1 one clock after the pulse. Write 0x00 to 0xFF0F → `irq_pending` = 0.
- In the same clock, write 0x00 to 0xFF0F and `irq_req[0]` = 1 → IF reads 0xE1.
- Read 0xC000 with `ext_din` = 0x3C → `ext_rd` high E0–E2, `ext_a` = 0xC000, `din` = 0x3C. Write 0x77 to 0x8000 → `ext_wr` is a single-cycle pulse at E3 with `ext_dout` = 0x77.
- Write 0x01 to 0xFF50 → `boot_en` = 0. A later write of 0x00 to 0xFF50 leaves it at 0. Asserting `rst` mid-write → no commit, and `boot_en` = 1.
